// File: rtl/bg_spr_shifter.sv
// Background/sprite pixel shifter feeding the PPU palette/priority mux.
// Holds one BG tile row plus a merged sprite overlay and advances one pixel per enabled clock.
module bg_spr_shifter (
  input  logic       clk,
  input  logic       nreset,
  input  logic       line_start,
  input  logic [2:0] scx_fine,
  input  logic       bg_load,
  input  logic [7:0] bg_data_a,
  input  logic [7:0] bg_data_b,
  input  logic       spr_load,
  input  logic [7:0] spr_data_a,
  input  logic [7:0] spr_data_b,
  input  logic       spr_flip_x,
  input  logic       spr_pal,
  input  logic       spr_behind,
  input  logic       shift_en,
  output logic       bg_pix_a_7,
  output logic       bg_pix_b_7,
  output logic [7:0] spr_pix_a,
  output logic [7:0] spr_pix_b,
  output logic       nobp0pixel,
  output logic       nobp1pixel,
  output logic       spr_behind_7,
  output logic       bg_empty,
  output logic       pix_valid
);

  logic [7:0] bga, bgb;
  logic [7:0] spa, spb, spal, sprio;
  logic [3:0] bg_cnt;
  logic [2:0] discard;

  logic       shift;
  logic       bg_accept;
  logic       opaque;
  logic [7:0] spr_row_a, spr_row_b;
  logic [7:0] spr_clear;

  function automatic logic [7:0] rev8(input logic [7:0] d);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = d[7-i];
    return r;
  endfunction

  // Replace only the transparent slots; existing opaque pixels belong to a lower-X sprite.
  function automatic logic [7:0] fill_clear(input logic [7:0] cur,
                                            input logic [7:0] src,
                                            input logic [7:0] clr);
    return (cur & ~clr) | (src & clr);
  endfunction

  function automatic logic [7:0] shl1(input logic [7:0] d);
    return {d[6:0], 1'b0};
  endfunction

  assign shift     = shift_en && (bg_cnt != 4'd0) && !spr_load && !line_start;
  assign bg_accept = bg_load && (bg_cnt == 4'd0);
  assign spr_row_a = spr_flip_x ? rev8(spr_data_a) : spr_data_a;
  assign spr_row_b = spr_flip_x ? rev8(spr_data_b) : spr_data_b;
  assign spr_clear = ~(spa | spb);

  always_ff @(posedge clk) begin
    if (!nreset) begin
      bga     <= 8'h00;
      bgb     <= 8'h00;
      spa     <= 8'h00;
      spb     <= 8'h00;
      spal    <= 8'h00;
      sprio   <= 8'h00;
      bg_cnt  <= 4'd0;
      discard <= 3'd0;
    end else if (line_start) begin
      bga     <= 8'h00;
      bgb     <= 8'h00;
      spa     <= 8'h00;
      spb     <= 8'h00;
      spal    <= 8'h00;
      sprio   <= 8'h00;
      bg_cnt  <= 4'd0;
      discard <= scx_fine;
    end else if (shift) begin
      bga    <= shl1(bga);
      bgb    <= shl1(bgb);
      spa    <= shl1(spa);
      spb    <= shl1(spb);
      spal   <= shl1(spal);
      sprio  <= shl1(sprio);
      bg_cnt <= bg_cnt - 4'd1;
      if (discard != 3'd0) discard <= discard - 3'd1;
    end else begin
      if (bg_accept) begin
        bga    <= bg_data_a;
        bgb    <= bg_data_b;
        bg_cnt <= 4'd8;
      end
      if (spr_load) begin
        spa   <= fill_clear(spa, spr_row_a, spr_clear);
        spb   <= fill_clear(spb, spr_row_b, spr_clear);
        spal  <= fill_clear(spal, {8{spr_pal}}, spr_clear);
        sprio <= fill_clear(sprio, {8{spr_behind}}, spr_clear);
      end
    end
  end

  assign opaque       = spa[7] | spb[7];
  assign bg_pix_a_7   = bga[7];
  assign bg_pix_b_7   = bgb[7];
  assign spr_pix_a    = spa;
  assign spr_pix_b    = spb;
  assign nobp0pixel   = !(opaque && !spal[7]);
  assign nobp1pixel   = !(opaque && spal[7]);
  assign spr_behind_7 = sprio[7];
  assign bg_empty     = (bg_cnt == 4'd0);
  assign pix_valid    = shift && (discard == 3'd0);

endmodule

// File: tb/tb_bg_spr_shifter.sv
// Table-driven scoreboard bench for bg_spr_shifter: each record holds one cycle of
// stimulus and the outputs expected around that cycle's rising edge.
module tb_bg_spr_shifter;

  logic       clk = 1'b0;
  logic       nreset;
  logic       line_start;
  logic [2:0] scx_fine;
  logic       bg_load;
  logic [7:0] bg_data_a, bg_data_b;
  logic       spr_load;
  logic [7:0] spr_data_a, spr_data_b;
  logic       spr_flip_x, spr_pal, spr_behind, shift_en;
  logic       bg_pix_a_7, bg_pix_b_7;
  logic [7:0] spr_pix_a, spr_pix_b;
  logic       nobp0pixel, nobp1pixel, spr_behind_7, bg_empty, pix_valid;

  always #5 clk = ~clk;

  bg_spr_shifter dut (
    .clk         (clk),
    .nreset      (nreset),
    .line_start  (line_start),
    .scx_fine    (scx_fine),
    .bg_load     (bg_load),
    .bg_data_a   (bg_data_a),
    .bg_data_b   (bg_data_b),
    .spr_load    (spr_load),
    .spr_data_a  (spr_data_a),
    .spr_data_b  (spr_data_b),
    .spr_flip_x  (spr_flip_x),
    .spr_pal     (spr_pal),
    .spr_behind  (spr_behind),
    .shift_en    (shift_en),
    .bg_pix_a_7  (bg_pix_a_7),
    .bg_pix_b_7  (bg_pix_b_7),
    .spr_pix_a   (spr_pix_a),
    .spr_pix_b   (spr_pix_b),
    .nobp0pixel  (nobp0pixel),
    .nobp1pixel  (nobp1pixel),
    .spr_behind_7(spr_behind_7),
    .bg_empty    (bg_empty),
    .pix_valid   (pix_valid)
  );

  typedef struct {
    logic       rst_n, ls;
    logic [2:0] scx;
    logic       bl;
    logic [7:0] ba, bb;
    logic       sl;
    logic [7:0] sa, sb;
    logic       fx, pal, beh, se;
    logic       pv;        // pix_valid before the edge
    logic       a7, b7;    // remaining fields: after the edge
    logic [7:0] espa, espb;
    logic       n0, n1, bh, emp;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   step = 0;

  function automatic vec_t idle();
    vec_t v;
    v = '{default: '0};
    v.rst_n = 1'b1;
    return v;
  endfunction

  function automatic vec_t st_rst();
    vec_t v = idle();
    v.rst_n = 1'b0;
    return v;
  endfunction

  function automatic vec_t st_sh();
    vec_t v = idle();
    v.se = 1'b1;
    return v;
  endfunction

  function automatic vec_t st_ls(input logic [2:0] scx);
    vec_t v = idle();
    v.ls  = 1'b1;
    v.scx = scx;
    return v;
  endfunction

  function automatic vec_t st_bl(input vec_t s, input logic [7:0] a, input logic [7:0] b);
    vec_t v = s;
    v.bl = 1'b1;
    v.ba = a;
    v.bb = b;
    return v;
  endfunction

  function automatic vec_t st_sl(input vec_t s, input logic [7:0] a, input logic [7:0] b,
                                 input logic fx, input logic pal, input logic beh);
    vec_t v = s;
    v.sl  = 1'b1;
    v.sa  = a;
    v.sb  = b;
    v.fx  = fx;
    v.pal = pal;
    v.beh = beh;
    return v;
  endfunction

  function automatic vec_t ex(input vec_t s, input logic pv, input logic a7, input logic b7,
                              input logic [7:0] espa, input logic [7:0] espb,
                              input logic n0, input logic n1, input logic bh, input logic emp);
    vec_t v = s;
    v.pv = pv; v.a7 = a7; v.b7 = b7; v.espa = espa; v.espb = espb;
    v.n0 = n0; v.n1 = n1; v.bh = bh; v.emp = emp;
    return v;
  endfunction

  task automatic chk1(input string nm, input logic got, input logic want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s step=%0d got=%0b want=%0b", nm, step, got, want);
    end
  endtask

  task automatic chk8(input string nm, input logic [7:0] got, input logic [7:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s step=%0d got=%02h want=%02h", nm, step, got, want);
    end
  endtask

  task automatic apply(input vec_t v);
    vec_t e;
    logic pv_seen;
    @(negedge clk);
    step++;
    nreset = v.rst_n; line_start = v.ls; scx_fine = v.scx;
    bg_load = v.bl; bg_data_a = v.ba; bg_data_b = v.bb;
    spr_load = v.sl; spr_data_a = v.sa; spr_data_b = v.sb;
    spr_flip_x = v.fx; spr_pal = v.pal; spr_behind = v.beh; shift_en = v.se;
    exp_q.push_back(v);
    #1 pv_seen = pix_valid;
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_empty step=%0d got=0 want=1", step);
    end else begin
      e = exp_q.pop_front();
      chk1("pix_valid", pv_seen, e.pv);
      chk1("bg_pix_a_7", bg_pix_a_7, e.a7);
      chk1("bg_pix_b_7", bg_pix_b_7, e.b7);
      chk8("spr_pix_a", spr_pix_a, e.espa);
      chk8("spr_pix_b", spr_pix_b, e.espb);
      chk1("nobp0pixel", nobp0pixel, e.n0);
      chk1("nobp1pixel", nobp1pixel, e.n1);
      chk1("spr_behind_7", spr_behind_7, e.bh);
      chk1("bg_empty", bg_empty, e.emp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog step=%0d got=timeout want=finish", step);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] seq_a;
    logic [7:0] seq_b;
    vec_t v;
    nreset = 1'b0; line_start = 1'b0; scx_fine = 3'd0;
    bg_load = 1'b0; bg_data_a = 8'h00; bg_data_b = 8'h00;
    spr_load = 1'b0; spr_data_a = 8'h00; spr_data_b = 8'h00;
    spr_flip_x = 1'b0; spr_pal = 1'b0; spr_behind = 1'b0; shift_en = 1'b0;

    // Reset values
    tbl.push_back(ex(st_rst(), 0, 0, 0, 8'h00, 8'h00, 1, 1, 0, 1));
    tbl.push_back(ex(st_rst(), 0, 0, 0, 8'h00, 8'h00, 1, 1, 0, 1));

    // BG A5/0F shifted out; bit k-1 from MSB gives the pixel after shift k
    seq_a = 8'b0100_1010;
    seq_b = 8'b0001_1110;
    tbl.push_back(ex(st_bl(idle(), 8'hA5, 8'h0F), 0, 1, 0, 8'h00, 8'h00, 1, 1, 0, 0));
    for (int k = 1; k <= 8; k++)
      tbl.push_back(ex(st_sh(), 1, seq_a[8-k], seq_b[8-k], 8'h00, 8'h00, 1, 1, 0, k == 8));
    tbl.push_back(ex(st_sh(), 0, 0, 0, 8'h00, 8'h00, 1, 1, 0, 1));

    // Fine-scroll discard of 3
    tbl.push_back(ex(st_ls(3'd3), 0, 0, 0, 8'h00, 8'h00, 1, 1, 0, 1));
    tbl.push_back(ex(st_bl(idle(), 8'hFF, 8'h00), 0, 1, 0, 8'h00, 8'h00, 1, 1, 0, 0));
    for (int k = 1; k <= 8; k++)
      tbl.push_back(ex(st_sh(), k > 3, k < 8, 0, 8'h00, 8'h00, 1, 1, 0, k == 8));

    // Two sprites merged: first (OBP1) keeps left half, second (OBP0, behind) fills the rest
    tbl.push_back(ex(st_bl(idle(), 8'h80, 8'h80), 0, 1, 1, 8'h00, 8'h00, 1, 1, 0, 0));
    tbl.push_back(ex(st_sl(idle(), 8'hF0, 8'h00, 0, 1, 0), 0, 1, 1, 8'hF0, 8'h00, 1, 0, 0, 0));
    tbl.push_back(ex(st_sl(idle(), 8'hFF, 8'hFF, 0, 0, 1), 0, 1, 1, 8'hFF, 8'h0F, 1, 0, 0, 0));
    tbl.push_back(ex(st_sh(), 1, 0, 0, 8'hFE, 8'h1E, 1, 0, 0, 0));
    tbl.push_back(ex(st_sh(), 1, 0, 0, 8'hFC, 8'h3C, 1, 0, 0, 0));
    tbl.push_back(ex(st_sh(), 1, 0, 0, 8'hF8, 8'h78, 1, 0, 0, 0));
    tbl.push_back(ex(st_sh(), 1, 0, 0, 8'hF0, 8'hF0, 0, 1, 1, 0));
    tbl.push_back(ex(st_sh(), 1, 0, 0, 8'hE0, 8'hE0, 0, 1, 1, 0));
    tbl.push_back(ex(st_sh(), 1, 0, 0, 8'hC0, 8'hC0, 0, 1, 1, 0));
    tbl.push_back(ex(st_sh(), 1, 0, 0, 8'h80, 8'h80, 0, 1, 1, 0));
    tbl.push_back(ex(st_sh(), 1, 0, 0, 8'h00, 8'h00, 1, 1, 0, 1));

    // x-flip with coincident bg_load
    tbl.push_back(ex(st_sl(st_bl(idle(), 8'h00, 8'h00), 8'h01, 8'h00, 1, 0, 0),
                     0, 0, 0, 8'h80, 8'h00, 0, 1, 0, 0));
    tbl.push_back(ex(st_sh(), 1, 0, 0, 8'h00, 8'h00, 1, 1, 0, 0));
    tbl.push_back(ex(st_sh(), 1, 0, 0, 8'h00, 8'h00, 1, 1, 0, 0));
    tbl.push_back(ex(st_sh(), 1, 0, 0, 8'h00, 8'h00, 1, 1, 0, 0));

    // bg_cnt == 5: spr_load blocks the shift, bg_load ignored, then 5 shifts remain
    tbl.push_back(ex(st_sl(st_sh(), 8'hC0, 8'h40, 0, 1, 1), 0, 0, 0, 8'hC0, 8'h40, 1, 0, 1, 0));
    tbl.push_back(ex(st_bl(idle(), 8'hFF, 8'hFF), 0, 0, 0, 8'hC0, 8'h40, 1, 0, 1, 0));
    tbl.push_back(ex(st_sh(), 1, 0, 0, 8'h80, 8'h80, 1, 0, 1, 0));
    tbl.push_back(ex(st_sh(), 1, 0, 0, 8'h00, 8'h00, 1, 1, 1, 0));
    tbl.push_back(ex(st_sh(), 1, 0, 0, 8'h00, 8'h00, 1, 1, 1, 0));
    tbl.push_back(ex(st_sh(), 1, 0, 0, 8'h00, 8'h00, 1, 1, 1, 0));
    tbl.push_back(ex(st_sh(), 1, 0, 0, 8'h00, 8'h00, 1, 1, 1, 1));
    tbl.push_back(ex(st_sh(), 0, 0, 0, 8'h00, 8'h00, 1, 1, 1, 1));

    // Mid-line reset
    tbl.push_back(ex(st_ls(3'd0), 0, 0, 0, 8'h00, 8'h00, 1, 1, 0, 1));
    tbl.push_back(ex(st_sl(st_bl(idle(), 8'hA5, 8'h0F), 8'hFF, 8'h00, 0, 0, 1),
                     0, 1, 0, 8'hFF, 8'h00, 0, 1, 1, 0));
    tbl.push_back(ex(st_sh(), 1, 0, 0, 8'hFE, 8'h00, 0, 1, 1, 0));
    tbl.push_back(ex(st_sh(), 1, 1, 0, 8'hFC, 8'h00, 0, 1, 1, 0));
    tbl.push_back(ex(st_sh(), 1, 0, 0, 8'hF8, 8'h00, 0, 1, 1, 0));
    tbl.push_back(ex(st_rst(), 0, 0, 0, 8'h00, 8'h00, 1, 1, 0, 1));
    tbl.push_back(ex(st_sh(), 0, 0, 0, 8'h00, 8'h00, 1, 1, 0, 1));

    foreach (tbl[i]) apply(tbl[i]);

    // Reset wins over a simultaneous line_start: discard must stay 0
    apply(ex(st_bl(idle(), 8'h80, 8'h00), 0, 1, 0, 8'h00, 8'h00, 1, 1, 0, 0));
    v = st_ls(3'd5);
    v.rst_n = 1'b0;
    apply(ex(v, 0, 0, 0, 8'h00, 8'h00, 1, 1, 0, 1));
    apply(ex(st_bl(idle(), 8'h80, 8'h80), 0, 1, 1, 8'h00, 8'h00, 1, 1, 0, 0));
    apply(ex(st_sh(), 1, 0, 0, 8'h00, 8'h00, 1, 1, 0, 0));

    // line_start overrides a concurrent shift and bg_load, then discards 2
    v = st_bl(st_ls(3'd2), 8'hFF, 8'hFF);
    v.se = 1'b1;
    apply(ex(v, 0, 0, 0, 8'h00, 8'h00, 1, 1, 0, 1));
    apply(ex(st_bl(idle(), 8'hFF, 8'hFF), 0, 1, 1, 8'h00, 8'h00, 1, 1, 0, 0));
    apply(ex(st_sh(), 0, 1, 1, 8'h00, 8'h00, 1, 1, 0, 0));
    apply(ex(st_sh(), 0, 1, 1, 8'h00, 8'h00, 1, 1, 0, 0));
    apply(ex(st_sh(), 1, 1, 1, 8'h00, 8'h00, 1, 1, 0, 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
